cpu6_trap_ctrl: RTL
===================

// Module: cpu6_trap_ctrl
// PURPOSE
//  - Parametrised trap/flush controller for the cpu6 core. Arbitrates between illegal-instruction
//    exceptions, mret, and NIRQ maskable interrupt channels.
//  - Runs a pipeline-drain handshake with a bounded timeout, then issues a one-cycle PC flush
//    together with the mepc/mcause CSR writes.
//  - Sits beside the fetch PC mux. Its flush and stall outputs override the branch and pc+4 paths.
// PARAMETERS
//  XLEN            32  datapath / PC width
//  NIRQ            4   number of interrupt channels (1..16)
//  IRQ_CAUSE_BASE  16  mcause code of channel 0; channel i = IRQ_CAUSE_BASE+i
//  DRAIN_TIMEOUT   15  max cycles spent in DRAIN before forced flush (>=1, counter $clog2(DRAIN_TIMEOUT+1) bits)
// PORTS
//  clk            in   1     clock, all state on rising edge
//  reset          in   1     synchronous, active-high
//  excp_illinstr  in   1     illegal instruction decoded this cycle
//  mret           in   1     mret decoded this cycle
//  excp_pc        in   XLEN  PC of the instruction being decoded
//  irq_i          in   NIRQ  level interrupt requests
//  irq_en         in   NIRQ  per-channel enable (mie bits)
//  glb_ie         in   1     global interrupt enable (mstatus.MIE)
//  csr_mtvec      in   XLEN  trap vector CSR
//  csr_mepc       in   XLEN  return address CSR
//  drain_req      out  1     request pipeline empty
//  drain_ack      in   1     pipeline empty (writeback drained)
//  stall          out  1     freeze fetch PC
//  flush_pc_ena   out  1     load flush_pc into fetch PC
//  flush_pc       out  XLEN  redirect target
//  mepc_wr        out  1     write mepc
//  mepc           out  XLEN  value for mepc
//  mcause_wr      out  1     write mcause
//  mcause         out  XLEN  value for mcause
//  irq_pending    out  NIRQ  irq_i & irq_en (combinational, mip view)
//  drain_timeout  out  1     one-cycle pulse: DRAIN left by timeout, not by ack
// BEHAVIOUR
//  - States: IDLE, DRAIN, FLUSH.
//  - Reset forces IDLE and zeroes the counter, the captured cause/pc, and every registered output.
//    irq_pending is combinational.
//  - IDLE, event priority:
//    1. excp_illinstr
//    2. mret
//    3. lowest-index channel with irq_pending[i] & glb_ie
//  - IDLE, on an event: capture kind, cause and pc=excp_pc. Next cycle the state is DRAIN.
//    Losers are not queued; a level irq that lost is re-evaluated on the next IDLE cycle.
//  - DRAIN: drain_req=1, stall=1, counter increments each cycle.
//    - drain_ack=1 -> FLUSH.
//    - Counter == DRAIN_TIMEOUT with no ack -> FLUSH and pulse drain_timeout.
//    - If ack arrives on the timeout cycle, ack wins and there is no pulse.
//  - FLUSH (exactly 1 cycle): flush_pc_ena=1, stall=0, drain_req=0. Returns to IDLE.
//    - Exception: flush_pc=vector, mepc_wr=1, mepc=captured pc, mcause_wr=1, mcause=2.
//    - Interrupt: flush_pc=vector, mepc_wr=1, mepc=captured pc, mcause_wr=1,
//      mcause={1'b1, (XLEN-1)'(IRQ_CAUSE_BASE+i)}.
//    - mret: flush_pc=csr_mepc sampled in FLUSH, no CSR writes.
//  - Events arriving in DRAIN or FLUSH are ignored. The pipeline is being flushed, so those
//    instructions are discarded; level irqs persist.
//  - Counter clears on entry to DRAIN.
//  - The cycle after FLUSH is IDLE, and an event is accepted in that IDLE cycle.
//    Back-to-back traps have a minimum spacing of 3 cycles.
//  - Outside FLUSH: flush_pc, mepc and mcause hold their last values, and all strobes are 0.
// CONFIGURATION
//  - CPU6_TRAP_VECTORED_EN defined:
//    - Interrupt with csr_mtvec[1:0]==2'b01 -> flush_pc = {mtvec[XLEN-1:2],2'b00} + 4*(IRQ_CAUSE_BASE+i).
//    - Exceptions always go to the base.
//  - CPU6_TRAP_VECTORED_EN undefined: every trap goes to {mtvec[XLEN-1:2],2'b00};
//    mtvec[1:0] is ignored.
// TESTING
//  - Reset: after reset, all outputs 0 and the state is IDLE, including when reset is asserted
//    mid-DRAIN with drain_req=1.
//  - Illegal instruction: excp_illinstr=1, excp_pc=0x100, mtvec=0x8000_0000, drain_ack after 3 cycles.
//    Expect drain_req/stall high for 3 cycles, then flush_pc=0x8000_0000, mepc=0x100, mcause=2, all for one cycle.
//  - Interrupt priority: irq_i=4'b1010, irq_en=4'hF, glb_ie=1.
//    Expect mcause=0x8000_0011, i.e. channel 1, cause 17.
//    Repeat with glb_ie=0 and expect no drain_req.
//  - Simultaneous excp_illinstr=1 and irq_i[0]=1: exception taken first with mcause=2.
//    IRQ taken on the next IDLE cycle with mcause=0x8000_0010.
//  - mret: csr_mepc=0x204, ack immediate. Expect flush_pc=0x204, mepc_wr=0, mcause_wr=0.
//  - Drain timeout: drain_ack held 0. Expect FLUSH exactly DRAIN_TIMEOUT cycles after DRAIN entry,
//    with a drain_timeout pulse.
//    With CPU6_TRAP_VECTORED_EN, mtvec=0x8000_0001, irq ch0: expect flush_pc=0x8000_0040.

Source files
------------

// File: rtl/cpu6_trap_ctrl_if.sv
// Trap controller bus: decode-side events, CSR views, drain handshake and
// the flush / CSR-write outputs toward the fetch PC mux and CSR file.
interface cpu6_trap_ctrl_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NIRQ = 4
);
    logic            excp_illinstr;
    logic            mret;
    logic [XLEN-1:0] excp_pc;
    logic [NIRQ-1:0] irq_i;
    logic [NIRQ-1:0] irq_en;
    logic            glb_ie;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            drain_req;
    logic            drain_ack;
    logic            stall;
    logic            flush_pc_ena;
    logic [XLEN-1:0] flush_pc;
    logic            mepc_wr;
    logic [XLEN-1:0] mepc;
    logic            mcause_wr;
    logic [XLEN-1:0] mcause;
    logic [NIRQ-1:0] irq_pending;
    logic            drain_timeout;

    // master: the trap controller
    modport master (
        input  excp_illinstr, mret, excp_pc, irq_i, irq_en, glb_ie,
               csr_mtvec, csr_mepc, drain_ack,
        output drain_req, stall, flush_pc_ena, flush_pc, mepc_wr, mepc,
               mcause_wr, mcause, irq_pending, drain_timeout
    );

    // slave: the core side (decode, fetch mux, CSR file)
    modport slave (
        output excp_illinstr, mret, excp_pc, irq_i, irq_en, glb_ie,
               csr_mtvec, csr_mepc, drain_ack,
        input  drain_req, stall, flush_pc_ena, flush_pc, mepc_wr, mepc,
               mcause_wr, mcause, irq_pending, drain_timeout
    );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// cpu6 trap/flush controller: arbitrates exception / mret / irq, drains the
// pipeline with a bounded timeout, then issues a one-cycle PC flush with CSR writes.
// Optional macro CPU6_TRAP_VECTORED_EN enables vectored interrupt targets.
module cpu6_trap_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NIRQ           = 4,
    parameter int unsigned IRQ_CAUSE_BASE = 16,
    parameter int unsigned DRAIN_TIMEOUT  = 15
) (
    input logic               clk,
    input logic               reset,
    cpu6_trap_ctrl_if.master  bus
);
    localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int unsigned IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_e;
    typedef enum logic [1:0] {K_NONE, K_EXC, K_MRET, K_IRQ} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [IW-1:0]   irq_idx_q, irq_idx_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain_req_q, drain_req_d;
    logic            stall_q, stall_d;
    logic            flush_pc_ena_q, flush_pc_ena_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic            sel_mepc_q, sel_mepc_d;
    logic            mepc_wr_q, mepc_wr_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            mcause_wr_q, mcause_wr_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            drain_timeout_q, drain_timeout_d;

    logic [NIRQ-1:0] irq_pending;
    logic            irq_hit;
    logic [IW-1:0]   irq_sel;
    logic [CW-1:0]   cnt_inc;
    logic            timeout_hit;
    logic [31:0]     irq_code;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;
    logic [XLEN-1:0] irq_mcause;

    assign irq_pending = bus.irq_i & bus.irq_en;

    // Fixed priority: lowest-index enabled channel wins
    always_comb begin
        irq_hit = 1'b0;
        irq_sel = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (!irq_hit && irq_pending[i] && bus.glb_ie) begin
                irq_hit = 1'b1;
                irq_sel = IW'(i);
            end
        end
    end

    assign irq_code   = 32'(IRQ_CAUSE_BASE) + 32'(irq_idx_q);
    assign irq_mcause = {1'b1, (XLEN-1)'(irq_code)};
    assign trap_base  = {bus.csr_mtvec[XLEN-1:2], 2'b00};

`ifdef CPU6_TRAP_VECTORED_EN
    assign irq_target = (bus.csr_mtvec[1:0] == 2'b01)
                      ? trap_base + (XLEN'(irq_code) << 2)
                      : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.csr_mtvec[1:0];
    assign irq_target        = trap_base;
`endif

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CW'(DRAIN_TIMEOUT));

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        irq_idx_d       = irq_idx_q;
        pc_d            = pc_q;
        cnt_d           = cnt_q;
        drain_req_d     = 1'b0;
        stall_d         = 1'b0;
        flush_pc_ena_d  = 1'b0;
        flush_pc_d      = flush_pc_q;
        sel_mepc_d      = 1'b0;
        mepc_wr_d       = 1'b0;
        mepc_d          = mepc_q;
        mcause_wr_d     = 1'b0;
        mcause_d        = mcause_q;
        drain_timeout_d = 1'b0;

        // mret target is live csr_mepc during FLUSH; latch it so the value holds afterwards
        if (sel_mepc_q) begin
            flush_pc_d = bus.csr_mepc;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.excp_illinstr || bus.mret || irq_hit) begin
                    if (bus.excp_illinstr) begin
                        kind_d = K_EXC;
                    end else if (bus.mret) begin
                        kind_d = K_MRET;
                    end else begin
                        kind_d    = K_IRQ;
                        irq_idx_d = irq_sel;
                    end
                    pc_d        = bus.excp_pc;
                    cnt_d       = '0;
                    state_d     = S_DRAIN;
                    drain_req_d = 1'b1;
                    stall_d     = 1'b1;
                end
            end

            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (bus.drain_ack || timeout_hit) begin
                    state_d         = S_FLUSH;
                    flush_pc_ena_d  = 1'b1;
                    drain_timeout_d = !bus.drain_ack;
                    case (kind_q)
                        K_EXC: begin
                            flush_pc_d  = trap_base;
                            mepc_wr_d   = 1'b1;
                            mepc_d      = pc_q;
                            mcause_wr_d = 1'b1;
                            mcause_d    = XLEN'(2);
                        end
                        K_IRQ: begin
                            flush_pc_d  = irq_target;
                            mepc_wr_d   = 1'b1;
                            mepc_d      = pc_q;
                            mcause_wr_d = 1'b1;
                            mcause_d    = irq_mcause;
                        end
                        K_MRET: begin
                            sel_mepc_d = 1'b1;
                        end
                        default: begin
                            sel_mepc_d = 1'b0;
                        end
                    endcase
                end else begin
                    drain_req_d = 1'b1;
                    stall_d     = 1'b1;
                end
            end

            S_FLUSH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            kind_q          <= K_NONE;
            irq_idx_q       <= '0;
            pc_q            <= '0;
            cnt_q           <= '0;
            drain_req_q     <= 1'b0;
            stall_q         <= 1'b0;
            flush_pc_ena_q  <= 1'b0;
            flush_pc_q      <= '0;
            sel_mepc_q      <= 1'b0;
            mepc_wr_q       <= 1'b0;
            mepc_q          <= '0;
            mcause_wr_q     <= 1'b0;
            mcause_q        <= '0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            irq_idx_q       <= irq_idx_d;
            pc_q            <= pc_d;
            cnt_q           <= cnt_d;
            drain_req_q     <= drain_req_d;
            stall_q         <= stall_d;
            flush_pc_ena_q  <= flush_pc_ena_d;
            flush_pc_q      <= flush_pc_d;
            sel_mepc_q      <= sel_mepc_d;
            mepc_wr_q       <= mepc_wr_d;
            mepc_q          <= mepc_d;
            mcause_wr_q     <= mcause_wr_d;
            mcause_q        <= mcause_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign bus.irq_pending   = irq_pending;
    assign bus.drain_req     = drain_req_q;
    assign bus.stall         = stall_q;
    assign bus.flush_pc_ena  = flush_pc_ena_q;
    assign bus.flush_pc      = sel_mepc_q ? bus.csr_mepc : flush_pc_q;
    assign bus.mepc_wr       = mepc_wr_q;
    assign bus.mepc          = mepc_q;
    assign bus.mcause_wr     = mcause_wr_q;
    assign bus.mcause        = mcause_q;
    assign bus.drain_timeout = drain_timeout_q;

endmodule
